// File: rtl/ram64_arbiter.sv
// Two-port round-robin sequencer in front of a single-port 64x16 RAM.
// Commands from two masters are serialised onto the RAM pins; read data returns on a shared bus.

module ram64_arbiter_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic gnt0,
    input  logic gnt1,
    input  logic rv0,
    input  logic rv1,
    input  logic ram_en,
    input  logic ram_r,
    input  logic ram_w
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
    a_rv_onehot:  assert property (@(posedge clk) disable iff (!rst_n) !(rv0 && rv1));
    a_rw_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(ram_r && ram_w));
    a_strobe_en:  assert property (@(posedge clk) disable iff (!rst_n) (ram_r || ram_w) |-> ram_en);
    a_en_gnt:     assert property (@(posedge clk) disable iff (!rst_n) ram_en == (gnt0 || gnt1));

endmodule

module ram64_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdat0,
    input  logic [DW-1:0] wdat1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rv0,
    output logic          rv1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          ram_en,
    output logic          ram_r,
    output logic          ram_w,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic          owner_r;
    logic          last_r;
    logic          we_r;

    logic          any_req_s;
    logic          win_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdat_s;

    logic          gnt0_nxt_s;
    logic          gnt1_nxt_s;
    logic          rv0_nxt_s;
    logic          rv1_nxt_s;
    logic          busy_nxt_s;
    logic          en_nxt_s;
    logic          r_nxt_s;
    logic          w_nxt_s;
    logic [AW-1:0] add_nxt_s;
    logic [DW-1:0] din_nxt_s;
    logic [DW-1:0] rdata_nxt_s;

    // Arbitration: single requester wins; on a tie the port not granted last wins.
    always_comb begin
        any_req_s = req0 | req1;
        if (req0 && req1) begin
            win_s = ~last_r;
        end else begin
            win_s = req1;
        end
        if (win_s) begin
            win_we_s   = we1;
            win_addr_s = addr1;
            win_wdat_s = wdat1;
        end else begin
            win_we_s   = we0;
            win_addr_s = addr0;
            win_wdat_s = wdat0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (we_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Command latch and read-latency counter; address/data are held in ram_add/ram_din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= 1'b0;
            last_r  <= 1'b1;
            we_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            if (state_r == IDLE && any_req_s) begin
                owner_r <= win_s;
                last_r  <= win_s;
                we_r    <= win_we_s;
            end
            if (state_r == ISSUE && !we_r) begin
                cnt_r <= CNT_LOAD;
            end else if (state_r == WAIT && cnt_r != CNT_ONE) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        gnt0_nxt_s  = 1'b0;
        gnt1_nxt_s  = 1'b0;
        rv0_nxt_s   = 1'b0;
        rv1_nxt_s   = 1'b0;
        en_nxt_s    = 1'b0;
        r_nxt_s     = 1'b0;
        w_nxt_s     = 1'b0;
        add_nxt_s   = ram_add;
        din_nxt_s   = ram_din;
        rdata_nxt_s = rdata;
        busy_nxt_s  = (state_nxt_s != IDLE);
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    gnt0_nxt_s = ~win_s;
                    gnt1_nxt_s = win_s;
                    en_nxt_s   = 1'b1;
                    add_nxt_s  = win_addr_s;
                    if (win_we_s) begin
                        w_nxt_s   = 1'b1;
                        din_nxt_s = win_wdat_s;
                    end else begin
                        r_nxt_s = 1'b1;
                    end
                end else begin
                    en_nxt_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    rdata_nxt_s = ram_dout;
                    rv0_nxt_s   = ~owner_r;
                    rv1_nxt_s   = owner_r;
                end else begin
                    rdata_nxt_s = rdata;
                end
            end
            default: en_nxt_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rv0     <= 1'b0;
            rv1     <= 1'b0;
            busy    <= 1'b0;
            ram_en  <= 1'b0;
            ram_r   <= 1'b0;
            ram_w   <= 1'b0;
            ram_add <= {AW{1'b0}};
            ram_din <= {DW{1'b0}};
            rdata   <= {DW{1'b0}};
        end else begin
            gnt0    <= gnt0_nxt_s;
            gnt1    <= gnt1_nxt_s;
            rv0     <= rv0_nxt_s;
            rv1     <= rv1_nxt_s;
            busy    <= busy_nxt_s;
            ram_en  <= en_nxt_s;
            ram_r   <= r_nxt_s;
            ram_w   <= w_nxt_s;
            ram_add <= add_nxt_s;
            ram_din <= din_nxt_s;
            rdata   <= rdata_nxt_s;
        end
    end

    ram64_arbiter_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .rv0    (rv0),
        .rv1    (rv1),
        .ram_en (ram_en),
        .ram_r  (ram_r),
        .ram_w  (ram_w)
    );

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: queued master commands, a behavioural RAM, and a
// transaction-level schedule model predicting grants, RAM pins and read returns.

module tb_ram64_arbiter;

    localparam int AW     = 6;
    localparam int DW     = 16;
    localparam int RD_LAT = 1;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdat0, wdat1;
    logic          gnt0, gnt1, rv0, rv1, busy;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_r, ram_w;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    ram64_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
        .gnt0(gnt0), .gnt1(gnt1), .rv0(rv0), .rv1(rv1),
        .rdata(rdata), .busy(busy),
        .ram_en(ram_en), .ram_r(ram_r), .ram_w(ram_w),
        .ram_add(ram_add), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural single-port RAM with one cycle of read latency.
    logic [DW-1:0] ram_mem [64];
    always @(posedge clk) begin
        if (ram_en && ram_w) ram_mem[ram_add] <= ram_din;
        if (ram_en && ram_r) ram_dout <= ram_mem[ram_add];
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc;
    int            next_sample;
    bit            last_m;
    logic [DW-1:0] mem_m [64];
    bit            rv_pend;
    int            rv_cyc;
    bit            rv_port;
    logic [DW-1:0] rv_data;
    logic [AW-1:0] exp_add;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_rdata;
    int            glog[$];
    cmd_t          q0[$];
    cmd_t          q1[$];
    bit            eager;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic cmd_t mk(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdat = d;
        return c;
    endfunction

    task automatic model_reset();
        next_sample = cyc;
        last_m      = 1'b1;
        rv_pend     = 1'b0;
        exp_add     = '0;
        exp_din     = '0;
        exp_rdata   = '0;
        req0 = 1'b0; req1 = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic step();
        bit e_g0, e_g1, e_en, e_r, e_w, e_rv0, e_rv1, e_busy, win, w_we;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_dat;
        cmd_t c;
        @(posedge clk); #1;
        cyc++;
        {e_g0, e_g1, e_en, e_r, e_w, e_rv0, e_rv1} = 7'b0;
        if (cyc >= next_sample) begin
            if (req0 || req1) begin
                if (req0 && req1) win = (last_m == 1'b0);
                else win = req1;
                last_m = win;
                w_we   = win ? we1 : we0;
                w_addr = win ? addr1 : addr0;
                w_dat  = win ? wdat1 : wdat0;
                if (win) e_g1 = 1'b1; else e_g0 = 1'b1;
                e_en    = 1'b1;
                exp_add = w_addr;
                if (w_we) begin
                    e_w = 1'b1;
                    exp_din = w_dat;
                    mem_m[w_addr] = w_dat;
                    next_sample = cyc + 2;
                end else begin
                    e_r = 1'b1;
                    rv_pend = 1'b1;
                    rv_cyc  = cyc + 1 + RD_LAT;
                    rv_port = win;
                    rv_data = mem_m[w_addr];
                    next_sample = cyc + 2 + RD_LAT;
                end
            end else begin
                next_sample = cyc + 1;
            end
        end
        if (rv_pend && rv_cyc == cyc) begin
            if (rv_port) e_rv1 = 1'b1; else e_rv0 = 1'b1;
            exp_rdata = rv_data;
            rv_pend   = 1'b0;
        end
        e_busy = (cyc < next_sample - 1);
        check_eq("gnt0",    32'(gnt0),    32'(e_g0));
        check_eq("gnt1",    32'(gnt1),    32'(e_g1));
        check_eq("rv0",     32'(rv0),     32'(e_rv0));
        check_eq("rv1",     32'(rv1),     32'(e_rv1));
        check_eq("busy",    32'(busy),    32'(e_busy));
        check_eq("ram_en",  32'(ram_en),  32'(e_en));
        check_eq("ram_r",   32'(ram_r),   32'(e_r));
        check_eq("ram_w",   32'(ram_w),   32'(e_w));
        check_eq("ram_add", 32'(ram_add), 32'(exp_add));
        check_eq("ram_din", 32'(ram_din), 32'(exp_din));
        check_eq("rdata",   32'(rdata),   32'(exp_rdata));
        if (gnt0) glog.push_back(0);
        if (gnt1) glog.push_back(1);
        // Masters: drop req after a grant, otherwise maybe present the next queued command.
        if (gnt0) req0 = 1'b0;
        else if (!req0 && q0.size() > 0 && (eager || $urandom_range(0, 1) == 1)) begin
            c = q0.pop_front();
            req0 = 1'b1; we0 = c.we; addr0 = c.addr; wdat0 = c.wdat;
        end
        if (gnt1) req1 = 1'b0;
        else if (!req1 && q1.size() > 0 && (eager || $urandom_range(0, 1) == 1)) begin
            c = q1.pop_front();
            req1 = 1'b1; we1 = c.we; addr1 = c.addr; wdat1 = c.wdat;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && !req0 && !req1 &&
                   !rv_pend && (cyc >= next_sample - 1);
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    initial begin
        cmd_t c;
        int   g;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;
        cyc = 0;
        eager = 1'b1;
        model_reset();
        #12;
        check_eq("rst_ctl",   32'({gnt0, gnt1, rv0, rv1, busy, ram_en, ram_r, ram_w}), 32'd0);
        check_eq("rst_add",   32'(ram_add), 32'd0);
        check_eq("rst_din",   32'(ram_din), 32'd0);
        check_eq("rst_rdata", 32'(rdata),   32'd0);
        #10 rst_n = 1'b1;

        // Preload every word so later random reads see defined data.
        for (int a = 0; a < 64; a++) begin
            c = mk(1'b1, 6'(a), 16'($urandom));
            if (a % 2 == 0) q0.push_back(c); else q1.push_back(c);
        end
        drain("preload", 1000);

        // T1: single write
        q0.push_back(mk(1'b1, 6'd2, 16'd1));
        drain("t1", 20);

        // T2: write then read from the other port
        q0.push_back(mk(1'b1, 6'd10, 16'h00AA));
        drain("t2w", 20);
        q1.push_back(mk(1'b0, 6'd10, 16'h0000));
        drain("t2r", 20);
        check_eq("t2_rdata", 32'(rdata), 32'h00AA);

        // T3: both ports held together for four commands
        glog.delete();
        q0.push_back(mk(1'b1, 6'd20, 16'h1111));
        q0.push_back(mk(1'b1, 6'd21, 16'h2222));
        q1.push_back(mk(1'b1, 6'd22, 16'h3333));
        q1.push_back(mk(1'b1, 6'd23, 16'h4444));
        drain("t3", 40);
        check_eq("t3_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            g = (glog.size() > i) ? glog[i] : -1;
            check_eq($sformatf("t3_order%0d", i), 32'(g), 32'(i % 2));
        end

        // T4: overwrite then read
        q0.push_back(mk(1'b1, 6'd32, 16'd9));
        q0.push_back(mk(1'b1, 6'd32, 16'd10));
        q0.push_back(mk(1'b0, 6'd32, 16'd0));
        drain("t4", 40);
        check_eq("t4_rdata", 32'(rdata), 32'd10);

        // T6: top address, all-ones data
        q1.push_back(mk(1'b1, 6'd63, 16'hFFFF));
        drain("t6w", 20);
        q0.push_back(mk(1'b0, 6'd63, 16'h0000));
        drain("t6r", 20);
        check_eq("t6_rdata", 32'(rdata), 32'hFFFF);

        // Randomized traffic on both ports
        eager = 1'b0;
        for (int i = 0; i < 300; i++) begin
            c = mk(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom));
            if ($urandom_range(0, 1) == 1) q1.push_back(c); else q0.push_back(c);
        end
        drain("rand", 6000);
        eager = 1'b1;

        // T5: reset asserted while a port-0 read is in WAIT
        q0.push_back(mk(1'b0, 6'd5, 16'h0000));
        step();
        step();
        check_eq("t5_gnt", 32'(gnt0), 32'd1);
        step();
        check_eq("t5_wait_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ctl",   32'({gnt0, gnt1, rv0, rv1, busy, ram_en, ram_r, ram_w}), 32'd0);
        check_eq("t5_rst_add",   32'(ram_add), 32'd0);
        check_eq("t5_rst_din",   32'(ram_din), 32'd0);
        check_eq("t5_rst_rdata", 32'(rdata),   32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) step();
        glog.delete();
        q0.push_back(mk(1'b1, 6'd7, 16'h0707));
        q1.push_back(mk(1'b1, 6'd8, 16'h0808));
        drain("t5_tie", 20);
        g = (glog.size() > 0) ? glog[0] : -1;
        check_eq("t5_first_tie", 32'(g), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
